// File: rtl/quick_rs232_pkg.sv
// Shared constants and types for the quick_rs232 receive engine.
package quick_rs232_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_IDLE
    } rx_state_e;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/quick_rs232_rx_fifo.sv
// First-word-fall-through FIFO with occupancy count; a pop frees room for a same-cycle push.
module quick_rs232_rx_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic [CW-1:0]    count_o,
    output logic [CW-1:0]    count_next_o,
    output logic             push_ok_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             empty;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop_i & ~empty;
    assign do_push = push_i & (~full | do_pop);

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    // Storage carries no reset; the output is forced to zero while empty.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    assign valid_o      = ~empty;
    assign data_o       = empty ? '0 : mem_q[rd_ptr_q];
    assign count_o      = count_q;
    assign count_next_o = count_d;
    assign push_ok_o    = do_push;

endmodule

// File: rtl/quick_rs232_rx.sv
// RS-232 receiver: synchroniser, 3-sample majority bit recovery, frame FSM,
// sticky error flags, FWFT receive FIFO and threshold CTS.
module quick_rs232_rx
    import quick_rs232_pkg::*;
#(
    parameter  int CLK_TICKS_PER_RS232_BIT = 434,
    parameter  int BYTE_LEN                = 8,
    parameter  int PARITY                  = 1,
    parameter  int STOP_BITS               = 1,
    parameter  int FIFO_DEPTH              = 16,
    parameter  int FLOW_CONTROL            = 1,
    parameter  int FLOW_THRESHOLD          = 12,
    localparam int CW                      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rx,
    output logic                cts,
    input  logic                rx_read,
    output logic [BYTE_LEN-1:0] rx_data,
    output logic                rx_valid,
    output logic [CW-1:0]       rx_count,
    output logic                rx_byte_received,
    output logic                rx_parity_err,
    output logic                rx_frame_err,
    output logic                rx_overrun,
    output logic                rx_err,
    input  logic                rx_err_clear
);

    localparam int TPB = CLK_TICKS_PER_RS232_BIT;
    localparam int H   = TPB / 2;
    localparam int TW  = $clog2(TPB);

    logic                rx_meta_q, rx_s_q, rx_s_prev_q, rd_prev_q;
    rx_state_e           state_q;
    logic [TW-1:0]       tick_q;
    logic [3:0]          bit_cnt_q;
    logic                stop_cnt_q;
    logic [1:0]          samp_q;
    logic [BYTE_LEN-1:0] shift_q;
    logic                par_acc_q, par_bad_q, stop_bad_q;

    logic                tick_end, at_s0, at_s1, at_mid, maj, start_edge, last_stop;
    logic                par_x, par_bit_bad, stop_bad_now;
    logic                frame_end, frame_good, par_set, frm_set, ovr_set;
    logic                pop_req, push_ok;
    logic [CW-1:0]       count_next;

    logic                par_err_q, frm_err_q, ovr_q, byte_rx_q, cts_q;
    logic                par_err_d, frm_err_d, ovr_d, cts_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            rx_s_prev_q <= 1'b1;
            rd_prev_q   <= 1'b0;
        end else begin
            rx_meta_q   <= rx;
            rx_s_q      <= rx_meta_q;
            rx_s_prev_q <= rx_s_q;
            rd_prev_q   <= rx_read;
        end
    end

    assign tick_end     = (tick_q == TW'(TPB - 1));
    assign at_s0        = (tick_q == TW'(H - 1));
    assign at_s1        = (tick_q == TW'(H));
    assign at_mid       = (tick_q == TW'(H + 1));
    assign maj          = majority3(samp_q[0], samp_q[1], rx_s_q);
    assign start_edge   = rx_s_prev_q & ~rx_s_q;
    assign last_stop    = (stop_cnt_q == 1'(STOP_BITS - 1));
    assign par_x        = par_acc_q ^ maj;
    assign par_bit_bad  = (PARITY == PARITY_ODD) ? ~par_x : par_x;
    assign stop_bad_now = stop_bad_q | ~maj;

    // Whole frame is judged once, at the majority point of the last stop bit.
    assign frame_end  = (state_q == S_STOP) && at_mid && last_stop;
    assign frame_good = frame_end & ~stop_bad_now & ~par_bad_q;
    assign par_set    = frame_end & par_bad_q;
    assign frm_set    = frame_end & stop_bad_now;
    assign ovr_set    = frame_good & ~push_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            tick_q     <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            samp_q     <= 2'b11;
            shift_q    <= '0;
            par_acc_q  <= 1'b0;
            par_bad_q  <= 1'b0;
            stop_bad_q <= 1'b0;
        end else begin
            if (at_s0) samp_q[0] <= rx_s_q;
            if (at_s1) samp_q[1] <= rx_s_q;
            if (state_q != S_IDLE && state_q != S_WAIT_IDLE) begin
                tick_q <= tick_end ? '0 : tick_q + TW'(1);
            end
            case (state_q)
                S_IDLE: begin
                    if (start_edge) begin
                        state_q <= S_START;
                        tick_q  <= '0;
                    end
                end
                S_START: begin
                    if (at_mid && maj) begin
                        state_q <= S_IDLE;
                    end else if (tick_end) begin
                        state_q   <= S_DATA;
                        bit_cnt_q <= '0;
                        par_acc_q <= 1'b0;
                    end
                end
                S_DATA: begin
                    if (at_mid) begin
                        shift_q   <= {maj, shift_q[BYTE_LEN-1:1]};
                        par_acc_q <= par_acc_q ^ maj;
                    end
                    if (tick_end) begin
                        if (bit_cnt_q == 4'(BYTE_LEN - 1)) begin
                            state_q    <= (PARITY == PARITY_NONE) ? S_STOP : S_PARITY;
                            stop_cnt_q <= 1'b0;
                            stop_bad_q <= 1'b0;
                            par_bad_q  <= 1'b0;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end
                    end
                end
                S_PARITY: begin
                    if (at_mid)   par_bad_q <= par_bit_bad;
                    if (tick_end) state_q   <= S_STOP;
                end
                S_STOP: begin
                    if (at_mid) begin
                        stop_bad_q <= stop_bad_now;
                        if (last_stop) state_q <= stop_bad_now ? S_WAIT_IDLE : S_IDLE;
                    end else if (tick_end) begin
                        stop_cnt_q <= stop_cnt_q + 1'b1;
                    end
                end
                S_WAIT_IDLE: begin
                    if (rx_s_q) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign pop_req = rx_read & ~rd_prev_q;

    quick_rs232_rx_fifo #(
        .WIDTH (BYTE_LEN),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i        (clk),
        .rst_i        (rst),
        .push_i       (frame_good),
        .data_i       (shift_q),
        .pop_i        (pop_req),
        .data_o       (rx_data),
        .valid_o      (rx_valid),
        .count_o      (rx_count),
        .count_next_o (count_next),
        .push_ok_o    (push_ok)
    );

    always_comb begin
        par_err_d = par_err_q | par_set;
        frm_err_d = frm_err_q | frm_set;
        ovr_d     = ovr_q | ovr_set;
        if (rx_err_clear) begin
            par_err_d = 1'b0;
            frm_err_d = 1'b0;
            ovr_d     = 1'b0;
        end
        cts_d = (FLOW_CONTROL == 0) ? 1'b1 : (count_next < CW'(FLOW_THRESHOLD));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
            ovr_q     <= 1'b0;
            byte_rx_q <= 1'b0;
            cts_q     <= 1'b0;
        end else begin
            par_err_q <= par_err_d;
            frm_err_q <= frm_err_d;
            ovr_q     <= ovr_d;
            byte_rx_q <= push_ok;
            cts_q     <= cts_d;
        end
    end

    assign rx_parity_err    = par_err_q;
    assign rx_frame_err     = frm_err_q;
    assign rx_overrun       = ovr_q;
    assign rx_err           = par_err_q | frm_err_q | ovr_q;
    assign rx_byte_received = byte_rx_q;
    assign cts              = cts_q;

endmodule
